// File: rtl/issue_ctrl.sv
// Instruction issue controller: buffers instructions in a FIFO, spaces fetches,
// enforces drain hazards, and emits delayed commit strobes.
module issue_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int T_D        = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PAYLOAD_W  = 32,
    parameter int COMMIT_LAT = T_D + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          inst_valid_i,
    output logic                          inst_ready_o,
    input  logic                          inst_fetch_i,
    input  logic                          inst_drain_i,
    input  logic                          inst_commit_i,
    input  logic [PAYLOAD_W-1:0]          inst_payload_i,
    input  logic                          flush_i,
    output logic                          fetch_valid_o,
    output logic                          fetch_drain_o,
    output logic [PAYLOAD_W-1:0]          fetch_payload_o,
    output logic                          commit_valid_o,
    output logic [PAYLOAD_W-1:0]          commit_payload_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = PAYLOAD_W + 3;
    localparam int IW = $clog2(ARRAY_SIZE) + 1;
    localparam int DW = $clog2(T_D) + 1;

    logic [EW-1:0]        mem_q [FIFO_DEPTH];
    logic [EW-1:0]        mem_d [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [IW-1:0]        issue_cnt_q, issue_cnt_d;
    logic [DW-1:0]        drain_cnt_q, drain_cnt_d;
    logic                 fetch_valid_q, fetch_valid_d;
    logic                 fetch_drain_q, fetch_drain_d;
    logic [PAYLOAD_W-1:0] fetch_payload_q, fetch_payload_d;
    logic [COMMIT_LAT-1:0] cv_q, cv_d;
    logic [PAYLOAD_W-1:0] cp_q [COMMIT_LAT];
    logic [PAYLOAD_W-1:0] cp_d [COMMIT_LAT];

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 issue;
    logic                 stall;
    logic [EW-1:0]        head;
    logic                 head_fetch;
    logic                 head_drain;
    logic                 head_commit;
    logic [PAYLOAD_W-1:0] head_payload;

    assign full         = (count_q == CW'(FIFO_DEPTH));
    assign empty        = (count_q == '0);
    assign head         = mem_q[rd_ptr_q];
    assign head_fetch   = head[EW-1];
    assign head_drain   = head[EW-2];
    assign head_commit  = head[EW-3];
    assign head_payload = head[PAYLOAD_W-1:0];

    // Head data is stale while empty, so issue is gated by !empty.
    assign stall = (issue_cnt_q != '0) || (head_drain && (drain_cnt_q != '0));
    assign issue = !empty && !stall && !flush_i;
    assign push  = inst_valid_i && !full && !flush_i;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {inst_fetch_i, inst_drain_i,
                                   inst_commit_i, inst_payload_i};
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (issue) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, issue})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_comb begin
        issue_cnt_d = (issue_cnt_q != '0) ? issue_cnt_q - IW'(1) : '0;
        drain_cnt_d = (drain_cnt_q != '0) ? drain_cnt_q - DW'(1) : '0;
        if (issue && head_fetch) begin
            issue_cnt_d = IW'(ARRAY_SIZE - 1);
        end
        if (issue && head_drain) begin
            drain_cnt_d = DW'(T_D - 1);
        end
        if (flush_i) begin
            issue_cnt_d = '0;
            drain_cnt_d = '0;
        end
    end

    always_comb begin
        fetch_valid_d   = issue && head_fetch;
        fetch_drain_d   = issue && head_fetch && head_drain;
        fetch_payload_d = fetch_payload_q;
        if (issue && head_fetch) begin
            fetch_payload_d = head_payload;
        end
    end

    // Each stage payload only moves with a valid, so the last stage holds
    // the most recent committed payload between strobes.
    always_comb begin
        cv_d  = cv_q;
        cp_d  = cp_q;
        cv_d[0] = issue && head_commit;
        if (issue && head_commit) begin
            cp_d[0] = head_payload;
        end
        for (int i = 1; i < COMMIT_LAT; i++) begin
            cv_d[i] = cv_q[i-1];
            if (cv_q[i-1]) begin
                cp_d[i] = cp_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            issue_cnt_q     <= '0;
            drain_cnt_q     <= '0;
            fetch_valid_q   <= 1'b0;
            fetch_drain_q   <= 1'b0;
            fetch_payload_q <= '0;
            cv_q            <= '0;
            for (int i = 0; i < COMMIT_LAT; i++) begin
                cp_q[i] <= '0;
            end
        end else begin
            mem_q           <= mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            issue_cnt_q     <= issue_cnt_d;
            drain_cnt_q     <= drain_cnt_d;
            fetch_valid_q   <= fetch_valid_d;
            fetch_drain_q   <= fetch_drain_d;
            fetch_payload_q <= fetch_payload_d;
            cv_q            <= cv_d;
            cp_q            <= cp_d;
        end
    end

    assign inst_ready_o     = !full;
    assign fifo_count_o     = count_q;
    assign fetch_valid_o    = fetch_valid_q;
    assign fetch_drain_o    = fetch_drain_q;
    assign fetch_payload_o  = fetch_payload_q;
    assign commit_valid_o   = cv_q[COMMIT_LAT-1];
    assign commit_payload_o = cp_q[COMMIT_LAT-1];
    assign busy_o = (count_q != '0) || (issue_cnt_q != '0) ||
                    (drain_cnt_q != '0);

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: vector table plus scoreboarded
// multi-cycle sequences for spacing, drain, commit, full, flush and reset.
module tb_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic        inst_fetch = 1'b0;
    logic        inst_drain = 1'b0;
    logic        inst_commit = 1'b0;
    logic [31:0] inst_payload = '0;
    logic        flush = 1'b0;
    logic        fetch_valid;
    logic        fetch_drain;
    logic [31:0] fetch_payload;
    logic        commit_valid;
    logic [31:0] commit_payload;
    logic [2:0]  fifo_count;
    logic        busy;

    issue_ctrl dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .inst_valid_i    (inst_valid),
        .inst_ready_o    (inst_ready),
        .inst_fetch_i    (inst_fetch),
        .inst_drain_i    (inst_drain),
        .inst_commit_i   (inst_commit),
        .inst_payload_i  (inst_payload),
        .flush_i         (flush),
        .fetch_valid_o   (fetch_valid),
        .fetch_drain_o   (fetch_drain),
        .fetch_payload_o (fetch_payload),
        .commit_valid_o  (commit_valid),
        .commit_payload_o(commit_payload),
        .fifo_count_o    (fifo_count),
        .busy_o          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic        drain;
        logic [31:0] pay;
    } ev_t;

    typedef struct {
        logic        f;
        logic        d;
        logic        c;
        logic [31:0] p;
        logic        ef;
        logic        ed;
        logic        ec;
    } vec_t;

    ev_t  fq[$];
    ev_t  cq[$];
    vec_t tbl[5];
    int   total = 0;
    int   passed = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (fetch_valid) begin
            if (fq.size() == 0) begin
                check("fetch_unexpected", {16'(cyc), 16'd0, fetch_payload}, 64'd0);
            end else begin
                e = fq.pop_front();
                check("fetch_event",
                      {16'(cyc), 15'd0, fetch_drain, fetch_payload},
                      {16'(e.at), 15'd0, e.drain, e.pay});
            end
        end
        if (commit_valid) begin
            if (cq.size() == 0) begin
                check("commit_unexpected", {16'(cyc), 16'd0, commit_payload}, 64'd0);
            end else begin
                e = cq.pop_front();
                check("commit_event", {16'(cyc), 16'd0, commit_payload},
                      {16'(e.at), 16'd0, e.pay});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic drive(input logic f, input logic d, input logic c,
                         input logic [31:0] p);
        inst_valid   = 1'b1;
        inst_fetch   = f;
        inst_drain   = d;
        inst_commit  = c;
        inst_payload = p;
        step();
        inst_valid = 1'b0;
    endtask

    task automatic exp_f(input int at, input logic dr, input logic [31:0] p);
        fq.push_back('{at, dr, p});
    endtask

    task automatic exp_c(input int at, input logic [31:0] p);
        cq.push_back('{at, 1'b0, p});
    endtask

    task automatic check_reset_outs(input string nm);
        check({nm, "_ready"}, inst_ready, 1);
        check({nm, "_flags"},
              {fetch_valid, fetch_drain, commit_valid, busy, fifo_count}, 0);
        check({nm, "_pay"}, {fetch_payload, commit_payload}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int n;
        logic saw_full;
        logic rdy_ok;
        logic [31:0] last_fp;
        logic [31:0] last_cp;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h1111_0001, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b1, 32'h2222_0002, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 32'h3333_0003, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h4444_0004, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 32'h5555_0005, 1'b0, 1'b0, 1'b0};

        #1 rst = 1'b1;
        #1;
        check_reset_outs("reset");
        step();
        step();
        rst = 1'b0;
        step();

        last_fp = '0;
        last_cp = '0;
        for (int i = 0; i < 5; i++) begin
            t = cyc;
            if (tbl[i].ef) begin
                exp_f(t + 2, tbl[i].ed, tbl[i].p);
                last_fp = tbl[i].p;
            end
            if (tbl[i].ec) begin
                exp_c(t + 10, tbl[i].p);
                last_cp = tbl[i].p;
            end
            drive(tbl[i].f, tbl[i].d, tbl[i].c, tbl[i].p);
            idle(14);
            check("vec_idle_busy", busy, 0);
            check("vec_fetch_hold", fetch_payload, last_fp);
            check("vec_commit_hold", commit_payload, last_cp);
        end

        // Back-to-back fetches
        t = cyc;
        exp_f(t + 2, 1'b0, 32'hA0);
        exp_f(t + 6, 1'b0, 32'hB0);
        drive(1'b1, 1'b0, 1'b0, 32'hA0);
        drive(1'b1, 1'b0, 1'b0, 32'hB0);
        idle(10);

        // Drain hazard
        t = cyc;
        exp_f(t + 2, 1'b1, 32'hA1);
        exp_f(t + 10, 1'b1, 32'hB1);
        rdy_ok = inst_ready;
        drive(1'b1, 1'b1, 1'b0, 32'hA1);
        rdy_ok &= inst_ready;
        drive(1'b1, 1'b1, 1'b0, 32'hB1);
        for (int i = 0; i < 12; i++) begin
            rdy_ok &= inst_ready;
            step();
        end
        check("drain_ready_high", rdy_ok, 1);
        idle(2);

        // Commit delay
        t = cyc;
        exp_f(t + 2, 1'b0, 32'h5A);
        exp_c(t + 10, 32'h5A);
        drive(1'b1, 1'b0, 1'b1, 32'h5A);
        idle(14);

        // Full and pointer wrap
        t = cyc;
        saw_full = 1'b0;
        for (int k = 0; k < 6; k++) exp_f(t + 2 + 4 * k, 1'b0, 32'h100 + k);
        for (int k = 0; k < 6; k++) begin
            inst_valid   = 1'b1;
            inst_fetch   = 1'b1;
            inst_drain   = 1'b0;
            inst_commit  = 1'b0;
            inst_payload = 32'h100 + k;
            n = 0;
            while (!inst_ready && n < 50) begin
                saw_full = 1'b1;
                check("full_count", fifo_count, 4);
                step();
                n++;
            end
            if (n >= 50) check("full_timeout", n, 0);
            step();
        end
        inst_valid = 1'b0;
        check("full_seen", saw_full, 1);
        idle(30);

        // Flush with commit in flight
        t = cyc;
        exp_f(t + 2, 1'b0, 32'hC0);
        exp_c(t + 10, 32'hC0);
        drive(1'b1, 1'b0, 1'b1, 32'hC0);
        drive(1'b1, 1'b0, 1'b0, 32'hC1);
        drive(1'b1, 1'b0, 1'b0, 32'hC2);
        drive(1'b1, 1'b0, 1'b0, 32'hC3);
        check("flush_pre_count", fifo_count, 3);
        flush        = 1'b1;
        inst_valid   = 1'b1;
        inst_payload = 32'hC4;
        step();
        flush      = 1'b0;
        inst_valid = 1'b0;
        check("flush_count", fifo_count, 0);
        check("flush_busy", busy, 0);
        idle(20);

        // Asynchronous reset mid-stream
        t = cyc;
        exp_f(t + 2, 1'b0, 32'hD0);
        drive(1'b1, 1'b0, 1'b1, 32'hD0);
        drive(1'b1, 1'b0, 1'b1, 32'hD1);
        #5;
        check("pre_rst_fetch", fetch_valid, 1);
        rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        @(posedge clk);
        @(posedge clk);
        #4 rst = 1'b0;
        idle(20);
        check("post_rst_busy", busy, 0);

        // First push right after release
        #2 rst = 1'b1;
        step();
        #5 rst = 1'b0;
        t = cyc;
        exp_f(t + 2, 1'b0, 32'hE0);
        inst_valid   = 1'b1;
        inst_fetch   = 1'b1;
        inst_drain   = 1'b0;
        inst_commit  = 1'b0;
        inst_payload = 32'hE0;
        step();
        inst_valid = 1'b0;
        check("first_push_count", fifo_count, 1);
        idle(6);

        check("fetch_queue_drained", fq.size(), 0);
        check("commit_queue_drained", cq.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
